interleaver: RTL and testbench

Block interleaver for the WiMax transmit chain. It sits directly downstream of the FEC encoder and consumes its serial coded bit stream (X/Y bits at the 100 MHz rate). It reorders each 192-bit coded block according to the 802.16 first permutation for QPSK (d = 16, s = 1). It then streams the block to the modulator. Storage is two 192-bit ping-pong banks, so one block is written while the previous one is read.

---
 rtl/interleaver_if.sv | 12 +
 rtl/interleaver.sv | 103 ++++++++++
 tb/tb_interleaver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/interleaver_if.sv
// interleaver_if: one-bit valid/ready stream link used on both sides of the interleaver
// Ports (signals):
//   valid - data carries a bit this cycle (master -> slave)
//   data  - the bit itself (master -> slave)
//   ready - slave accepts the bit this cycle (slave -> master)
interface interleaver_if;
    logic valid;
    logic data;
    logic ready;
    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/interleaver.sv
// interleaver: 802.16 QPSK block interleaver (first permutation) with ping-pong bit banks
// Ports:
//   clock_100 - single rising-edge clock
//   reset     - asynchronous active-high reset, discards all blocks
//   in_s      - coded bit stream from FEC (valid/data in, ready out)
//   out_m     - interleaved bit stream to modulator (valid/data out, ready in)
module interleaver #(
    parameter int NCBPS = 192,
    parameter int D     = 16
) (
    input logic           clock_100,
    input logic           reset,
    interleaver_if.slave  in_s,
    interleaver_if.master out_m
);
    localparam int ROWS = NCBPS / D;
    localparam int AW   = $clog2(NCBPS);
    localparam int CW   = $clog2(D);
    localparam int RW   = $clog2(ROWS);

    logic [NCBPS-1:0] bank_q [2];
    logic [NCBPS-1:0] bank_d [2];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    k_q, k_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             wr_fire, rd_fire;

    // Handshake outputs come from registers only; out_data is masked while idle.
    assign in_s.ready  = !full_q[wr_bank_q];
    assign out_m.valid = full_q[rd_bank_q];
    assign out_m.data  = full_q[rd_bank_q] & bank_q[rd_bank_q][rd_addr_q];
    assign wr_fire     = in_s.valid && !full_q[wr_bank_q];
    assign rd_fire     = full_q[rd_bank_q] && out_m.ready;

    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        k_d       = k_q;
        rd_addr_d = rd_addr_q;
        if (wr_fire) begin
            bank_d[wr_bank_q][addr_q] = in_s.data;
            // Writer walks the column-major address ROWS*col + row without a multiplier.
            if (k_q == AW'(NCBPS - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                col_d             = '0;
                row_d             = '0;
                addr_d            = '0;
                k_d               = '0;
            end else begin
                k_d    = k_q + AW'(1);
                col_d  = (col_q == CW'(D - 1)) ? '0 : col_q + CW'(1);
                row_d  = (col_q == CW'(D - 1)) ? row_q + RW'(1) : row_q;
                addr_d = (col_q == CW'(D - 1)) ? AW'(row_q) + AW'(1) : addr_q + AW'(ROWS);
            end
        end
        // Reader only touches a full bank and writer only an empty one, so the two
        // full_d updates never target the same bank on one edge.
        if (rd_fire) begin
            if (rd_addr_q == AW'(NCBPS - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_addr_d         = '0;
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            bank_q    <= '{default: '0};
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            k_q       <= '0;
            rd_addr_q <= '0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            k_q       <= k_d;
            rd_addr_q <= rd_addr_d;
        end
    end
endmodule

// File: tb/tb_interleaver.sv
// tb_interleaver: directed self-checking bench for the QPSK block interleaver
module tb_interleaver;
    logic clock_100 = 1'b0;
    logic reset;
    always #5 clock_100 = ~clock_100;

    interleaver_if in_if ();
    interleaver_if out_if ();

    interleaver dut (
        .clock_100 (clock_100),
        .reset     (reset),
        .in_s      (in_if),
        .out_m     (out_if)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int nr_cnt = 0;
    int first_emit = -1;
    int last_emit = -1;
    int first_ready;
    logic in_q[$];
    logic out_q[$];
    logic [191:0] b0, b1, b2;
    logic d0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference order: output n = 12c + r carries input k = 16r + c.
    function automatic logic [191:0] perm(input logic [191:0] blk);
        logic [191:0] v;
        for (int n = 0; n < 192; n++) v[n] = blk[16 * (n % 12) + n / 12];
        return v;
    endfunction

    function automatic logic [191:0] got(input int base);
        logic [191:0] v;
        for (int n = 0; n < 192; n++) v[n] = (base + n < out_q.size()) ? out_q[base + n] : 1'bx;
        return v;
    endfunction

    task automatic push_blk(input logic [191:0] blk);
        for (int k = 0; k < 192; k++) in_q.push_back(blk[k]);
    endtask

    task automatic clear_stats();
        in_q.delete();
        out_q.delete();
        cyc = 0;
        nr_cnt = 0;
        first_emit = -1;
        last_emit = -1;
    endtask

    // One clock: drive at posedge+1, observe handshakes at negedge, then advance.
    task automatic cycle(input int pv, input logic ordy);
        logic iv;
        iv = (in_q.size() > 0) && ($urandom_range(99) < pv);
        in_if.valid = iv;
        in_if.data = iv ? in_q[0] : 1'b0;
        out_if.ready = ordy;
        @(negedge clock_100);
        if (!in_if.ready) nr_cnt++;
        if (iv && in_if.ready) void'(in_q.pop_front());
        if (out_if.valid && ordy) begin
            out_q.push_back(out_if.data);
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
        end
        @(posedge clock_100);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        in_if.valid = 1'b0;
        in_if.data = 1'b0;
        out_if.ready = 1'b0;
        @(posedge clock_100);
        #1;
        check("rst_in_ready", 192'(in_if.ready), 192'd1);
        check("rst_out_valid", 192'(out_if.valid), 192'd0);
        check("rst_out_data", 192'(out_if.data), 192'd0);
        reset = 1'b0;

        // Single marker bit at k = 16 must appear at n = 1.
        clear_stats();
        b0 = 192'd0;
        b0[16] = 1'b1;
        push_blk(b0);
        for (int i = 0; i < 400 && in_q.size() > 0; i++) cycle(100, 1'b1);
        check("marker_no_early_out", 192'(out_q.size()), 192'd0);
        check("marker_in_ready", 192'(nr_cnt), 192'd0);
        check("marker_latency_valid", 192'(out_if.valid), 192'd1);
        check("marker_first_data", 192'(out_if.data), 192'd0);
        for (int i = 0; i < 400 && out_q.size() < 192; i++) cycle(100, 1'b1);
        check("marker_data", got(0), 192'd2);
        check("marker_drain_cycles", 192'(last_emit - first_emit), 192'd191);
        check("marker_valid_low", 192'(out_if.valid), 192'd0);

        // Three back-to-back random blocks, no stalls on either side.
        clear_stats();
        b0 = rnd_blk();
        b1 = rnd_blk();
        b2 = rnd_blk();
        push_blk(b0);
        push_blk(b1);
        push_blk(b2);
        for (int i = 0; i < 1000 && out_q.size() < 576; i++) cycle(100, 1'b1);
        check("perm_blk0", got(0), perm(b0));
        check("perm_blk1", got(192), perm(b1));
        check("perm_blk2", got(384), perm(b2));
        check("perm_in_ready", 192'(nr_cnt), 192'd0);
        check("perm_first_emit", 192'(first_emit), 192'd192);
        check("perm_no_gaps", 192'(last_emit - first_emit), 192'd575);

        // Backpressure: both banks fill, writer stalls until bank 0 drains.
        clear_stats();
        b0 = rnd_blk();
        b1 = rnd_blk();
        push_blk(b0);
        push_blk(b1);
        for (int i = 0; i < 500 && in_q.size() > 0; i++) cycle(100, 1'b0);
        check("bp_fill_cycles", 192'(cyc), 192'd384);
        check("bp_in_ready_low", 192'(in_if.ready), 192'd0);
        check("bp_out_valid", 192'(out_if.valid), 192'd1);
        d0 = out_if.data;
        check("bp_head_bit", 192'(d0), 192'(b0[0]));
        repeat (5) cycle(100, 1'b0);
        check("bp_data_stable", 192'(out_if.data), 192'(d0));
        check("bp_valid_stable", 192'(out_if.valid), 192'd1);
        check("bp_still_stalled", 192'(in_if.ready), 192'd0);
        first_ready = -1;
        for (int i = 1; i <= 200; i++) begin
            cycle(100, 1'b1);
            if (in_if.ready && first_ready < 0) first_ready = i;
        end
        check("bp_resume_edge", 192'(first_ready), 192'd192);
        for (int i = 0; i < 400 && out_q.size() < 384; i++) cycle(100, 1'b1);
        check("bp_blk0", got(0), perm(b0));
        check("bp_blk1", got(192), perm(b1));
        repeat (10) cycle(100, 1'b1);
        check("bp_no_extra", 192'(out_q.size()), 192'd384);

        // Sparse input and random output stalls.
        clear_stats();
        b0 = rnd_blk();
        b1 = rnd_blk();
        push_blk(b0);
        push_blk(b1);
        for (int i = 0; i < 4000 && out_q.size() < 384; i++) cycle(50, $urandom_range(3) != 0);
        check("sparse_blk0", got(0), perm(b0));
        check("sparse_blk1", got(192), perm(b1));

        // Mid-block reset with one full block pending and a partial one filling.
        clear_stats();
        b0 = rnd_blk();
        push_blk(b0);
        for (int k = 0; k < 100; k++) in_q.push_back(1'($urandom_range(1)));
        for (int i = 0; i < 500 && in_q.size() > 0; i++) cycle(100, 1'b0);
        check("mr_pre_valid", 192'(out_if.valid), 192'd1);
        in_if.valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mr_in_ready", 192'(in_if.ready), 192'd1);
        check("mr_out_valid", 192'(out_if.valid), 192'd0);
        check("mr_out_data", 192'(out_if.data), 192'd0);
        @(posedge clock_100);
        #1;
        reset = 1'b0;
        clear_stats();
        push_blk({192{1'b1}});
        for (int i = 0; i < 500 && out_q.size() < 192; i++) cycle(100, 1'b1);
        check("mr_all_ones", got(0), {192{1'b1}});
        repeat (20) cycle(100, 1'b1);
        check("mr_exact_count", 192'(out_q.size()), 192'd192);
        clear_stats();
        b0 = rnd_blk();
        push_blk(b0);
        for (int i = 0; i < 500 && out_q.size() < 192; i++) cycle(100, 1'b1);
        check("mr_after_perm", got(0), perm(b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
